// File: rtl/loop_pkg.sv
// loop_pkg: shared constants and command encoding for the loop counter stack
package loop_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_LVL_W = $clog2(DEF_DEPTH + 1);
    typedef enum logic [2:0] {CMD_NONE, CMD_PUSH, CMD_POP, CMD_REPLACE, CMD_DEC} cmd_e;
endpackage

// File: rtl/loop_entry.sv
// loop_entry: one loop-count register with load and saturating decrement
// Ports: clk, rst (async, active-high), ld_i load d_i, dec_i decrement (holds at 0), q_o stored count
module loop_entry #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic             dec_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= '0;
        else if (ld_i) q_q <= d_i;
        else if (dec_i && q_q != '0) q_q <= q_q - 1'b1;
    end
    assign q_o = q_q;
endmodule

// File: rtl/loop_stack.sv
// loop_stack: nested-loop counter stack with push/pop/replace/decrement and sticky error
// Ports: clk, rst (async, active-high); bus_to_ls count in; push, pop, decrement commands;
//        ls_to_bus top count (0 when empty), lrz_flag top==1, empty, full, level, err (sticky).
// Option: define LOOP_STACK_AUTOPOP_EN so a decrement on a top of 1 pops the entry instead of writing 0.
module loop_stack
    import loop_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           bus_to_ls,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       decrement,
    output logic [WIDTH-1:0]           ls_to_bus,
    output logic                       lrz_flag,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);
    localparam int LW = $clog2(DEPTH + 1);
    logic [LW-1:0] level_q, level_d;
    logic err_q, err_d, pop_auto;
    cmd_e cmd;
    logic [DEPTH-1:0][WIDTH-1:0] ent;
    logic [WIDTH-1:0] top;
    // push+pop on an empty stack has no top to replace, so it degrades to a push
    assign cmd = (push && pop) ? (empty ? CMD_PUSH : CMD_REPLACE) :
                 push ? CMD_PUSH : pop ? CMD_POP : decrement ? CMD_DEC : CMD_NONE;
`ifdef LOOP_STACK_AUTOPOP_EN
    assign pop_auto = (cmd == CMD_DEC) && lrz_flag;
`else
    assign pop_auto = 1'b0;
`endif
    assign level_d = (cmd == CMD_PUSH && !full) ? level_q + 1'b1 :
                     ((cmd == CMD_POP && !empty) || pop_auto) ? level_q - 1'b1 : level_q;
    assign err_d = err_q | (cmd == CMD_PUSH && full) | ((cmd == CMD_POP || cmd == CMD_DEC) && empty);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            err_q   <= err_d;
        end
    end
    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        loop_entry #(.WIDTH(WIDTH)) u_entry (
            .clk  (clk),
            .rst  (rst),
            .ld_i ((cmd == CMD_PUSH && !full && level_q == LW'(k)) ||
                   (cmd == CMD_REPLACE && level_q == LW'(k + 1))),
            .dec_i(cmd == CMD_DEC && !pop_auto && level_q == LW'(k + 1)),
            .d_i  (bus_to_ls),
            .q_o  (ent[k])
        );
    end
    // level 0 selects nothing, which masks stale popped slots to 0
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) top = (level_q == LW'(i + 1)) ? ent[i] : top;
    end
    assign ls_to_bus = top;
    assign lrz_flag  = top == WIDTH'(1);
    assign empty     = level_q == '0;
    assign full      = level_q == LW'(DEPTH);
    assign level     = level_q;
    assign err       = err_q;
endmodule

// File: tb/tb_loop_stack.sv
// tb_loop_stack: table-driven directed check of loop_stack (WIDTH=16, DEPTH=4)
module tb_loop_stack;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_to_ls = '0;
    logic        push = 1'b0, pop = 1'b0, decrement = 1'b0;
    logic [15:0] ls_to_bus;
    logic        lrz_flag, empty, full, err;
    logic [2:0]  level;
    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        rs, pu, po, de;
        logic [15:0] bus, top;
        logic [2:0]  lvl;
        logic        lrz, emp, ful, er;
    } vec_t;
    vec_t v[$];

    loop_stack #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus_to_ls(bus_to_ls), .push(push), .pop(pop),
        .decrement(decrement), .ls_to_bus(ls_to_bus), .lrz_flag(lrz_flag),
        .empty(empty), .full(full), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rs, pu, po, de, input logic [15:0] bus, top,
                       input logic [2:0] lvl, input logic lrz, emp, ful, er);
        vec_t t;
        t.rs = rs; t.pu = pu; t.po = po; t.de = de; t.bus = bus; t.top = top;
        t.lvl = lvl; t.lrz = lrz; t.emp = emp; t.ful = ful; t.er = er;
        v.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] top, input logic [2:0] lvl,
                         input logic lrz, emp, ful, er);
        checks++;
        if ({ls_to_bus, level, lrz_flag, empty, full, err} === {top, lvl, lrz, emp, ful, er})
            passes++;
        else
            $display("FAIL %s: got top=%0d lvl=%0d lrz=%b empty=%b full=%b err=%b, want top=%0d lvl=%0d lrz=%b empty=%b full=%b err=%b",
                     name, ls_to_bus, level, lrz_flag, empty, full, err, top, lvl, lrz, emp, ful, er);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic cmd(input logic pu, po, de, input logic [15:0] bus);
        @(negedge clk);
        push = pu; pop = po; decrement = de; bus_to_ls = bus;
        @(negedge clk);
        push = 1'b0; pop = 1'b0; decrement = 1'b0; bus_to_ls = '0;
    endtask

    initial begin
        //   rs pu po de bus  top lvl lrz emp ful err
        add(1, 1, 0, 0, 5,   5,  1,  0,  0,  0,  0);
        add(0, 1, 0, 0, 3,   3,  2,  0,  0,  0,  0);
        add(0, 0, 1, 0, 0,   5,  1,  0,  0,  0,  0);
        add(0, 1, 0, 0, 2,   2,  2,  0,  0,  0,  0);
        add(0, 0, 0, 1, 0,   1,  2,  1,  0,  0,  0);
`ifdef LOOP_STACK_AUTOPOP_EN
        add(0, 0, 0, 1, 0,   5,  1,  0,  0,  0,  0);
`else
        add(0, 0, 0, 1, 0,   0,  2,  0,  0,  0,  0);
`endif
        add(1, 1, 0, 0, 4,   4,  1,  0,  0,  0,  0);
        add(0, 1, 0, 0, 8,   8,  2,  0,  0,  0,  0);
        add(0, 1, 1, 0, 9,   9,  2,  0,  0,  0,  0);
        add(0, 0, 1, 0, 0,   4,  1,  0,  0,  0,  0);
        add(0, 1, 0, 1, 7,   7,  2,  0,  0,  0,  0);
        add(0, 0, 1, 0, 0,   4,  1,  0,  0,  0,  0);
        add(0, 1, 0, 0, 0,   0,  2,  0,  0,  0,  0);
        add(0, 0, 0, 1, 0,   0,  2,  0,  0,  0,  0);
        add(0, 1, 0, 0, 6,   6,  3,  0,  0,  0,  0);
        add(0, 1, 0, 0, 1,   1,  4,  1,  0,  1,  0);
        add(0, 1, 0, 0, 11,  1,  4,  1,  0,  1,  1);
        add(0, 0, 1, 0, 0,   6,  3,  0,  0,  0,  1);
        add(0, 0, 1, 0, 0,   0,  2,  0,  0,  0,  1);
        add(0, 0, 1, 0, 0,   4,  1,  0,  0,  0,  1);
        add(0, 0, 1, 0, 0,   0,  0,  0,  1,  0,  1);
        add(0, 0, 1, 0, 0,   0,  0,  0,  1,  0,  1);
        add(1, 1, 1, 0, 9,   9,  1,  0,  0,  0,  0);
        add(0, 0, 1, 0, 0,   0,  0,  0,  1,  0,  0);
        add(0, 0, 0, 1, 0,   0,  0,  0,  1,  0,  1);
        add(1, 0, 0, 0, 0,   0,  0,  0,  1,  0,  0);

        #2 check("reset_async", 0, 0, 0, 1, 0, 0);
        do_reset();
        check("reset_release", 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < v.size(); i++) begin
            if (v[i].rs) do_reset();
            cmd(v[i].pu, v[i].po, v[i].de, v[i].bus);
            check($sformatf("vec%0d", i), v[i].top, v[i].lvl, v[i].lrz, v[i].emp, v[i].ful, v[i].er);
        end

        do_reset();
        cmd(1, 0, 0, 16'd1);
        cmd(1, 0, 0, 16'd2);
        cmd(1, 0, 0, 16'd3);
        check("pre_midreset", 3, 3, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("mid_cycle_reset", 0, 0, 0, 1, 0, 0);
        @(negedge clk) rst = 1'b0;
        cmd(0, 1, 0, 0);
        check("pop_after_midreset", 0, 0, 0, 1, 0, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
